// File: rtl/rgmii_transmit_controller.sv
// rtl/rgmii_transmit_controller.sv - RGMII TX sequencer: preamble/SFD, padding, underrun abort, inter-packet gap
// Output registers always carry the byte belonging to the state being entered, so each state sees its own byte on the pins.
module rgmii_transmit_controller #(
  parameter int PREAMBLE_BYTES  = 7,
  parameter int IPG_BYTES       = 12,
  parameter int MIN_FRAME_BYTES = 60,
  parameter int COUNT_WIDTH     = 32
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [7:0]             s_axis_data,
  input  logic                   s_axis_valid,
  input  logic                   s_axis_last,
  output logic                   s_axis_ready,
  output logic [7:0]             ddr_data,
  output logic [1:0]             ddr_control,
  output logic                   busy,
  output logic                   underrun,
  output logic [COUNT_WIDTH-1:0] frame_count
);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_PREAMBLE = 3'd1;
  localparam logic [2:0] ST_SFD      = 3'd2;
  localparam logic [2:0] ST_PAYLOAD  = 3'd3;
  localparam logic [2:0] ST_PAD      = 3'd4;
  localparam logic [2:0] ST_DISCARD  = 3'd5;
  localparam logic [2:0] ST_GAP      = 3'd6;

  localparam int PW = $clog2(PREAMBLE_BYTES + 1);
  // One spare code above MIN_FRAME_BYTES so payload_cnt+1 never wraps when saturated.
  localparam int CW = $clog2(MIN_FRAME_BYTES + 2);
  localparam int GW = $clog2(IPG_BYTES + 1);

  localparam logic [PW-1:0] PRE_LAST = PW'(PREAMBLE_BYTES);
  localparam logic [CW-1:0] MIN_LEN  = CW'(MIN_FRAME_BYTES);
  localparam logic [GW-1:0] GAP_LAST = GW'(IPG_BYTES - 1);

  logic [2:0]    state;
  logic [PW-1:0] pre_cnt;
  logic [CW-1:0] payload_cnt;
  logic [GW-1:0] gap_cnt;

  assign s_axis_ready = (state == ST_SFD) || (state == ST_PAYLOAD) || (state == ST_DISCARD);
  assign busy         = (state != ST_IDLE);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      pre_cnt     <= '0;
      payload_cnt <= '0;
      gap_cnt     <= '0;
      ddr_data    <= 8'h00;
      ddr_control <= 2'b00;
      underrun    <= 1'b0;
      frame_count <= '0;
    end else begin
      ddr_data    <= 8'h00;
      ddr_control <= 2'b00;
      underrun    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (s_axis_valid) begin
            ddr_data    <= 8'h55;
            ddr_control <= 2'b11;
            pre_cnt     <= PW'(1);
            state       <= ST_PREAMBLE;
          end
        end
        ST_PREAMBLE: begin
          ddr_control <= 2'b11;
          if (pre_cnt == PRE_LAST) begin
            ddr_data    <= 8'hD5;
            payload_cnt <= '0;
            state       <= ST_SFD;
          end else begin
            ddr_data <= 8'h55;
            pre_cnt  <= pre_cnt + 1'b1;
          end
        end
        ST_SFD, ST_PAYLOAD: begin
          if (s_axis_valid) begin
            ddr_data    <= s_axis_data;
            ddr_control <= 2'b11;
            if (payload_cnt != MIN_LEN) payload_cnt <= payload_cnt + 1'b1;
            if (!s_axis_last) begin
              state <= ST_PAYLOAD;
            end else if (payload_cnt + 1'b1 < MIN_LEN) begin
              state <= ST_PAD;
            end else begin
              gap_cnt     <= '0;
              frame_count <= frame_count + 1'b1;
              state       <= ST_GAP;
            end
          end else begin
            ddr_control <= 2'b01;
            underrun    <= 1'b1;
            state       <= ST_DISCARD;
          end
        end
        ST_PAD: begin
          ddr_control <= 2'b11;
          payload_cnt <= payload_cnt + 1'b1;
          if (payload_cnt + 1'b1 == MIN_LEN) begin
            gap_cnt     <= '0;
            frame_count <= frame_count + 1'b1;
            state       <= ST_GAP;
          end
        end
        ST_DISCARD: begin
          if (s_axis_valid && s_axis_last) begin
            gap_cnt <= '0;
            state   <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (gap_cnt == GAP_LAST) state <= ST_IDLE;
          else gap_cnt <= gap_cnt + 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rgmii_transmit_controller.sv
// tb/tb_rgmii_transmit_controller.sv - directed bench for rgmii_transmit_controller
module tb_rgmii_transmit_controller;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  s_axis_data = 8'h00;
  logic        s_axis_valid = 1'b0;
  logic        s_axis_last = 1'b0;
  logic        s_axis_ready;
  logic [7:0]  ddr_data;
  logic [1:0]  ddr_control;
  logic        busy;
  logic        underrun;
  logic [31:0] frame_count;

  int checks = 0;
  int failures = 0;

  logic [7:0]  ld[$];
  logic [1:0]  lc[$];
  logic        lr[$];
  logic        lu[$];
  logic        lb[$];
  logic [31:0] lf[$];

  rgmii_transmit_controller dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .s_axis_data  (s_axis_data),
    .s_axis_valid (s_axis_valid),
    .s_axis_last  (s_axis_last),
    .s_axis_ready (s_axis_ready),
    .ddr_data     (ddr_data),
    .ddr_control  (ddr_control),
    .busy         (busy),
    .underrun     (underrun),
    .frame_count  (frame_count)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] pat(input int i);
    return 8'((i * 37 + 5) & 255);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    ld.delete(); lc.delete(); lr.delete(); lu.delete(); lb.delete(); lf.delete();
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
    ld.push_back(ddr_data);
    lc.push_back(ddr_control);
    lr.push_back(s_axis_ready);
    lu.push_back(underrun);
    lb.push_back(busy);
    lf.push_back(frame_count);
  endtask

  function automatic int bad_const(input int s, input int n, input logic [7:0] d, input logic [1:0] c);
    int bad = 0;
    for (int k = s; k < s + n; k++)
      if (k >= ld.size() || ld[k] !== d || lc[k] !== c) bad++;
    return bad;
  endfunction

  function automatic int bad_pat(input int s, input int n, input int base);
    int bad = 0;
    for (int k = 0; k < n; k++)
      if (s + k >= ld.size() || ld[s+k] !== pat(base + k) || lc[s+k] !== 2'b11) bad++;
    return bad;
  endfunction

  function automatic int run11(input int s);
    int r = 0;
    while (s + r < lc.size() && lc[s+r] === 2'b11) r++;
    return r;
  endfunction

  function automatic int count_ready();
    int n = 0;
    foreach (lr[k]) if (lr[k] === 1'b1) n++;
    return n;
  endfunction

  function automatic int count_und();
    int n = 0;
    foreach (lu[k]) if (lu[k] === 1'b1) n++;
    return n;
  endfunction

  // Streams n_frames frames of len bytes, optionally stalling valid for stall_len cycles after byte stall_after.
  task automatic stream(input int n_frames, input int len, input int stall_after, input int stall_len, input int tail);
    int total, idx, stalls, cnt;
    bit acc;
    total = n_frames * len;
    idx = 0; stalls = 0; cnt = 0;
    clear_logs();
    while (idx < total && cnt < 3000) begin
      if (stall_after > 0 && idx == stall_after && stalls < stall_len) begin
        s_axis_valid = 1'b0;
        stalls++;
      end else begin
        s_axis_valid = 1'b1;
      end
      s_axis_data = pat(idx);
      s_axis_last = ((idx % len) == len - 1);
      acc = s_axis_valid && s_axis_ready;
      cyc();
      if (acc) idx++;
      cnt++;
    end
    s_axis_valid = 1'b0;
    s_axis_last = 1'b0;
    s_axis_data = 8'h00;
    chk("stream_done", 64'(idx), 64'(total));
    repeat (tail) cyc();
  endtask

  initial begin
    int bad;
    #2;
    chk("reset_ctl", 64'(ddr_control), 64'(2'b00));
    chk("reset_data", 64'(ddr_data), 64'(8'h00));
    chk("reset_ready_busy_und", 64'({s_axis_ready, busy, underrun}), 64'(3'b000));
    chk("reset_fc", 64'(frame_count), 64'(0));
    #10;
    reset_n = 1'b1;

    // 64-byte frame
    stream(1, 64, 0, 0, 80);
    chk("t1_preamble", 64'(bad_const(0, 7, 8'h55, 2'b11)), 64'(0));
    chk("t1_sfd", 64'({lc[7], ld[7]}), 64'({2'b11, 8'hD5}));
    chk("t1_payload", 64'(bad_pat(8, 64, 0)), 64'(0));
    chk("t1_ctl_run", 64'(run11(0)), 64'(72));
    chk("t1_gap_idle", 64'(bad_const(72, 12, 8'h00, 2'b00)), 64'(0));
    chk("t1_ready_cycles", 64'(count_ready()), 64'(64));
    chk("t1_frame_count", 64'(frame_count), 64'(1));

    // 10-byte frame padded to 60
    stream(1, 10, 0, 0, 80);
    chk("t2_payload", 64'(bad_pat(8, 10, 0)), 64'(0));
    chk("t2_pad", 64'(bad_const(18, 50, 8'h00, 2'b11)), 64'(0));
    chk("t2_ctl_run", 64'(run11(0)), 64'(68));
    chk("t2_fc_during_pad", 64'(lf[66]), 64'(1));
    chk("t2_frame_count", 64'(frame_count), 64'(2));

    // 1-byte frame
    stream(1, 1, 0, 0, 80);
    chk("t3_byte", 64'(bad_pat(8, 1, 0)), 64'(0));
    chk("t3_pad", 64'(bad_const(9, 59, 8'h00, 2'b11)), 64'(0));
    chk("t3_ctl_run", 64'(run11(0)), 64'(68));
    chk("t3_gap_entered", 64'({lb[68], lc[68], lr[68]}), 64'({1'b1, 2'b00, 1'b0}));
    chk("t3_idle_after", 64'(lb[85]), 64'(0));
    chk("t3_frame_count", 64'(frame_count), 64'(3));

    // 100-byte frame with underrun after byte 20
    stream(1, 100, 20, 3, 80);
    chk("t4_head", 64'(bad_pat(8, 20, 0)), 64'(0));
    chk("t4_err_byte", 64'({lc[28], ld[28]}), 64'({2'b01, 8'h00}));
    chk("t4_underrun_pos", 64'(lu[28]), 64'(1));
    chk("t4_underrun_count", 64'(count_und()), 64'(1));
    chk("t4_ctl_quiet", 64'(bad_const(29, 150, 8'h00, 2'b00)), 64'(0));
    chk("t4_frame_count", 64'(frame_count), 64'(3));
    chk("t4_idle_after", 64'(lb[150]), 64'(0));

    // two back-to-back 64-byte frames
    stream(2, 64, 0, 0, 80);
    chk("t5_f1_payload", 64'(bad_pat(8, 64, 0)), 64'(0));
    chk("t5_gap", 64'(bad_const(72, 12, 8'h00, 2'b00)), 64'(0));
    chk("t5_next_preamble_at_13", 64'({lc[84], ld[84]}), 64'({2'b11, 8'h55}));
    chk("t5_f2_preamble", 64'(bad_const(84, 7, 8'h55, 2'b11)), 64'(0));
    chk("t5_f2_payload", 64'(bad_pat(92, 64, 64)), 64'(0));
    chk("t5_frame_count", 64'(frame_count), 64'(5));

    // reset asserted mid-payload
    clear_logs();
    for (int i = 0; i < 20; i++) begin
      s_axis_valid = 1'b1;
      s_axis_data = pat(i);
      s_axis_last = 1'b0;
      cyc();
    end
    chk("t6_in_payload", 64'({busy, s_axis_ready, ddr_control}), 64'({1'b1, 1'b1, 2'b11}));
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6_async_ctl_data", 64'({ddr_control, ddr_data}), 64'({2'b00, 8'h00}));
    chk("t6_async_ready_busy", 64'({s_axis_ready, busy}), 64'(2'b00));
    chk("t6_async_fc", 64'(frame_count), 64'(0));
    s_axis_valid = 1'b0;
    s_axis_last = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    clear_logs();
    repeat (20) cyc();
    bad = 0;
    for (int k = 0; k < 20; k++) if (lb[k] !== 1'b0 || lc[k] !== 2'b00) bad++;
    chk("t6_stays_idle", 64'(bad), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
